// File: rtl/xor_result_scheduler.sv
// xor_result_scheduler
//   Collects block-match results (XOR map, confidence, min coords) from
//   num_engines matcher engines, which may finish out of order, and issues
//   them one at a time to the xors_to_stream datapath in raster column order.
//   Issues are spaced by the datapath write occupancy (blk_h cycles of
//   holdoff). Row credits stop column 0 of a new row from entering a
//   ping-pong buffer that is still being streamed out.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   eng_valid/eng_ready   per-engine handshake; eng_ready is one-hot or zero
//   eng_blk_col           per-engine block column (col_bits each)
//   eng_xors/conf/coords  per-engine result payloads
//   xors_out/conf_out/coords_out  payload of the last issued block
//   xors_valid            one-cycle issue strobe
//   pix_stream_valid      datapath read beat, returns row credits
//   rows_in_flight        rows issued but not yet drained (0..2)
//   row_issued            pulses with the strobe of the last column of a row
//   dup_err               sticky: duplicate column offered or stray read beat
module xor_result_scheduler #(
    parameter int num_engines     = 4,
    parameter int blk_w           = 16,
    parameter int blk_h           = 16,
    parameter int frame_w         = 240,
    parameter int decimate_factor = 2,
    parameter int beats_per_row   = frame_w * blk_h / decimate_factor,
    parameter int col_bits        = $clog2(frame_w / blk_w)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [num_engines-1:0]             eng_valid,
    output logic [num_engines-1:0]             eng_ready,
    input  logic [num_engines*col_bits-1:0]    eng_blk_col,
    input  logic [num_engines*blk_w*blk_h-1:0] eng_xors,
    input  logic [num_engines*8-1:0]           eng_conf,
    input  logic [num_engines*16-1:0]          eng_coords,
    output logic [blk_w*blk_h-1:0]             xors_out,
    output logic [7:0]                         conf_out,
    output logic [15:0]                        coords_out,
    output logic                               xors_valid,
    input  logic                               pix_stream_valid,
    output logic [1:0]                         rows_in_flight,
    output logic                               row_issued,
    output logic                               dup_err
);

    localparam int blocks_per_row = frame_w / blk_w;
    localparam int xw             = blk_w * blk_h;
    localparam int hold_bits      = $clog2(blk_h + 1);
    localparam int beat_bits      = $clog2(beats_per_row);

    localparam logic [col_bits-1:0]  last_col  = col_bits'(blocks_per_row - 1);
    localparam logic [beat_bits-1:0] last_beat = beat_bits'(beats_per_row - 1);
    localparam logic [hold_bits-1:0] hold_load = hold_bits'(blk_h);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_CREDIT_WAIT
    } state_t;

    state_t                 state;
    logic [col_bits-1:0]    exp_col;
    logic [hold_bits-1:0]   holdoff;
    logic [beat_bits-1:0]   beat_cnt;

    logic                   eligible;
    logic                   found;
    logic                   xfer;
    logic                   multi_match;
    logic                   beat_ok;
    logic                   row_inc;
    logic                   row_dec;
    logic [num_engines-1:0] match;
    logic [num_engines-1:0] onehot;
    logic [xw-1:0]          sel_xors;
    logic [7:0]             sel_conf;
    logic [15:0]            sel_coords;

    // State is a view of the counters, not separately stored.
    always_comb begin
        if (holdoff != '0)
            state = S_HOLD;
        else if (exp_col == '0 && rows_in_flight == 2'd2)
            state = S_CREDIT_WAIT;
        else
            state = S_IDLE;
    end

    assign eligible = (state == S_IDLE);

    // Lowest-index engine offering the expected column wins.
    always_comb begin
        found      = 1'b0;
        match      = '0;
        onehot     = '0;
        sel_xors   = '0;
        sel_conf   = '0;
        sel_coords = '0;
        for (int unsigned i = 0; i < num_engines; i++) begin
            match[i] = eng_valid[i] && (eng_blk_col[i*col_bits +: col_bits] == exp_col);
            if (match[i] && !found) begin
                found      = 1'b1;
                onehot[i]  = 1'b1;
                sel_xors   = eng_xors[i*xw +: xw];
                sel_conf   = eng_conf[i*8 +: 8];
                sel_coords = eng_coords[i*16 +: 16];
            end
        end
    end

    // Grants are masked while reset is held so no engine sees a handshake.
    assign eng_ready   = (eligible && reset_n) ? onehot : '0;
    assign xfer        = |eng_ready;
    assign multi_match = eligible && ($countones(match) > 1);
    assign beat_ok     = pix_stream_valid && (rows_in_flight != 2'd0);
    assign row_inc     = xfer && (exp_col == last_col);
    assign row_dec     = beat_ok && (beat_cnt == last_beat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_col        <= '0;
            holdoff        <= '0;
            beat_cnt       <= '0;
            rows_in_flight <= '0;
            xors_valid     <= 1'b0;
            row_issued     <= 1'b0;
            dup_err        <= 1'b0;
            xors_out       <= '0;
            conf_out       <= '0;
            coords_out     <= '0;
        end else begin
            xors_valid <= xfer;
            row_issued <= row_inc;

            if (xfer) begin
                xors_out   <= sel_xors;
                conf_out   <= sel_conf;
                coords_out <= sel_coords;
                holdoff    <= hold_load;
                exp_col    <= (exp_col == last_col) ? '0 : exp_col + 1'b1;
            end else if (holdoff != '0) begin
                holdoff <= holdoff - 1'b1;
            end

            // Beats with nothing in flight are ignored (flagged below).
            if (beat_ok)
                beat_cnt <= (beat_cnt == last_beat) ? '0 : beat_cnt + 1'b1;

            if (row_inc && !row_dec)
                rows_in_flight <= rows_in_flight + 2'd1;
            else if (row_dec && !row_inc)
                rows_in_flight <= rows_in_flight - 2'd1;

            if (multi_match || (pix_stream_valid && rows_in_flight == 2'd0))
                dup_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xor_result_scheduler.sv
// tb_xor_result_scheduler
//   Directed bench for xor_result_scheduler with default parameters
//   (4 engines, 15 columns per row, 1920 beats per row, holdoff 16).
module tb_xor_result_scheduler;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    eng_valid;
    logic [3:0]    eng_ready;
    logic [15:0]   eng_blk_col;
    logic [1023:0] eng_xors;
    logic [31:0]   eng_conf;
    logic [63:0]   eng_coords;
    logic [255:0]  xors_out;
    logic [7:0]    conf_out;
    logic [15:0]   coords_out;
    logic          xors_valid;
    logic          pix_stream_valid;
    logic [1:0]    rows_in_flight;
    logic          row_issued;
    logic          dup_err;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int last_issue;

    xor_result_scheduler #(
        .num_engines     (4),
        .blk_w           (16),
        .blk_h           (16),
        .frame_w         (240),
        .decimate_factor (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .eng_valid        (eng_valid),
        .eng_ready        (eng_ready),
        .eng_blk_col      (eng_blk_col),
        .eng_xors         (eng_xors),
        .eng_conf         (eng_conf),
        .eng_coords       (eng_coords),
        .xors_out         (xors_out),
        .conf_out         (conf_out),
        .coords_out       (coords_out),
        .xors_valid       (xors_valid),
        .pix_stream_valid (pix_stream_valid),
        .rows_in_flight   (rows_in_flight),
        .row_issued       (row_issued),
        .dup_err          (dup_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] mk_x(input int t);
        logic [255:0] v;
        for (int w = 0; w < 8; w++)
            v[w*32 +: 32] = (32'(t) * 32'h9E37_79B1) ^ 32'(w * 16'h1111);
        return v;
    endfunction

    function automatic logic [7:0] mk_c(input int t);
        return 8'(t * 7 + 3);
    endfunction

    function automatic logic [15:0] mk_k(input int t);
        return 16'(t * 257 + 11);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int i, input int col, input int t);
        eng_valid[i]              = 1'b1;
        eng_blk_col[i*4 +: 4]     = 4'(col);
        eng_xors[i*256 +: 256]    = mk_x(t);
        eng_conf[i*8 +: 8]        = mk_c(t);
        eng_coords[i*16 +: 16]    = mk_k(t);
    endtask

    task automatic withdraw(input int i);
        eng_valid[i] = 1'b0;
    endtask

    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (eng_ready[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Wait for engine i to be granted, take the transfer edge, check the issue.
    task automatic issue(input int i, input int t, input logic exp_row, input string nm);
        bit         ok;
        logic [3:0] oh;
        wait_grant(i, ok);
        chk({nm, " grant"}, 256'(ok), 256'(1));
        oh = 4'b0001 << i;
        chk({nm, " onehot"}, 256'(eng_ready), 256'(oh));
        tick();
        chk({nm, " valid"}, 256'(xors_valid), 256'(1));
        chk({nm, " xors"}, xors_out, mk_x(t));
        chk({nm, " conf"}, 256'(conf_out), 256'(mk_c(t)));
        chk({nm, " coords"}, 256'(coords_out), 256'(mk_k(t)));
        chk({nm, " row_issued"}, 256'(row_issued), 256'(exp_row));
        last_issue = cyc;
        withdraw(i);
    endtask

    initial begin
        int prev;
        int pulses;

        reset_n          = 1'b0;
        eng_valid        = '0;
        eng_blk_col      = '0;
        eng_xors         = '0;
        eng_conf         = '0;
        eng_coords       = '0;
        pix_stream_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst xors_valid", 256'(xors_valid), 256'(0));
        chk("rst xors_out", xors_out, 256'(0));
        chk("rst conf", 256'(conf_out), 256'(0));
        chk("rst coords", 256'(coords_out), 256'(0));
        chk("rst rif", 256'(rows_in_flight), 256'(0));
        chk("rst row_issued", 256'(row_issued), 256'(0));
        chk("rst dup_err", 256'(dup_err), 256'(0));
        chk("rst eng_ready", 256'(eng_ready), 256'(0));
        reset_n = 1'b1;

        // Row A: single engine, columns 0..14, spacing 17 cycles
        prev = 0;
        for (int c = 0; c < 15; c++) begin
            present(0, c, 100 + c);
            #1;
            issue(0, 100 + c, (c == 14), $sformatf("rowA c%0d", c));
            if (c > 0)
                chk($sformatf("rowA spacing c%0d", c), 256'(last_issue - prev), 256'(17));
            prev = last_issue;
        end
        chk("rowA rif", 256'(rows_in_flight), 256'(1));
        tick();
        chk("rowA strobe drops", 256'(xors_valid), 256'(0));
        chk("rowA xors hold", xors_out, mk_x(114));

        // Row B cols 0..3 offered out of order by all engines at once
        present(0, 3, 200);
        present(1, 1, 201);
        present(2, 0, 202);
        present(3, 2, 203);
        #1;
        issue(2, 202, 1'b0, "ooo e2");
        issue(1, 201, 1'b0, "ooo e1");
        issue(3, 203, 1'b0, "ooo e3");
        issue(0, 200, 1'b0, "ooo e0");
        chk("ooo dup_err", 256'(dup_err), 256'(0));

        // Finish row B with no read beats: two rows in flight
        for (int c = 4; c < 15; c++) begin
            present(0, c, 300 + c);
            #1;
            issue(0, 300 + c, (c == 14), $sformatf("rowB c%0d", c));
        end
        chk("rowB rif", 256'(rows_in_flight), 256'(2));

        // Column 0 of row C is blocked until a whole row drains
        present(0, 0, 400);
        for (int k = 0; k < 20; k++) tick();
        chk("credit blocked ready", 256'(eng_ready), 256'(0));
        chk("credit blocked rif", 256'(rows_in_flight), 256'(2));
        pix_stream_valid = 1'b1;
        for (int k = 0; k < 1919; k++) tick();
        chk("credit 1919 ready", 256'(eng_ready), 256'(0));
        chk("credit 1919 rif", 256'(rows_in_flight), 256'(2));
        tick();
        pix_stream_valid = 1'b0;
        chk("credit drained rif", 256'(rows_in_flight), 256'(1));
        chk("credit immediate grant", 256'(eng_ready), 256'(1));
        issue(0, 400, 1'b0, "rowC c0");

        // Row C: last beat of row B drains in the same edge col 14 issues
        for (int c = 1; c < 14; c++) begin
            present(0, c, 500 + c);
            #1;
            issue(0, 500 + c, 1'b0, $sformatf("rowC c%0d", c));
        end
        pix_stream_valid = 1'b1;
        for (int k = 0; k < 1919; k++) tick();
        present(0, 14, 514);
        #1;
        chk("coincide ready", 256'(eng_ready), 256'(1));
        chk("coincide rif before", 256'(rows_in_flight), 256'(1));
        tick();
        pix_stream_valid = 1'b0;
        withdraw(0);
        chk("coincide valid", 256'(xors_valid), 256'(1));
        chk("coincide row_issued", 256'(row_issued), 256'(1));
        chk("coincide xors", xors_out, mk_x(514));
        chk("coincide rif after", 256'(rows_in_flight), 256'(1));
        tick();
        chk("coincide rif settled", 256'(rows_in_flight), 256'(1));

        // Engines 1 and 3 both offer column 0
        present(1, 0, 601);
        present(3, 0, 603);
        #1;
        begin
            bit ok;
            wait_grant(1, ok);
            chk("dup grant", 256'(ok), 256'(1));
        end
        chk("dup onehot", 256'(eng_ready), 256'(4'b0010));
        chk("dup err before", 256'(dup_err), 256'(0));
        tick();
        withdraw(1);
        chk("dup valid", 256'(xors_valid), 256'(1));
        chk("dup xors e1", xors_out, mk_x(601));
        chk("dup conf e1", 256'(conf_out), 256'(mk_c(601)));
        chk("dup err set", 256'(dup_err), 256'(1));
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (xors_valid === 1'b1) pulses++;
        end
        chk("dup e3 not granted", 256'(eng_ready), 256'(0));
        chk("dup no extra issue", 256'(pulses), 256'(0));
        chk("dup err sticky", 256'(dup_err), 256'(1));
        withdraw(3);

        // Reset in the middle of holdoff with a captured block
        present(0, 1, 700);
        #1;
        issue(0, 700, 1'b0, "pre-reset c1");
        tick();
        tick();
        tick();
        present(2, 0, 710);
        reset_n = 1'b0;
        #1;
        chk("mid rst valid", 256'(xors_valid), 256'(0));
        chk("mid rst xors", xors_out, 256'(0));
        chk("mid rst conf", 256'(conf_out), 256'(0));
        chk("mid rst coords", 256'(coords_out), 256'(0));
        chk("mid rst row_issued", 256'(row_issued), 256'(0));
        chk("mid rst dup_err", 256'(dup_err), 256'(0));
        chk("mid rst rif", 256'(rows_in_flight), 256'(0));
        chk("mid rst ready", 256'(eng_ready), 256'(0));
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (xors_valid !== 1'b0) pulses++;
        end
        chk("mid rst no strobe", 256'(pulses), 256'(0));
        reset_n = 1'b1;
        #1;
        chk("post rst grant", 256'(eng_ready), 256'(4'b0100));
        tick();
        withdraw(2);
        chk("post rst valid", 256'(xors_valid), 256'(1));
        chk("post rst xors", xors_out, mk_x(710));
        chk("post rst coords", 256'(coords_out), 256'(mk_k(710)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
